// File: rtl/bcd_seg_disp_seq.sv
// rtl/bcd_seg_disp_seq.sv - sequential signed binary-to-BCD converter with N-digit seven-segment driver
module bcd_seg_disp_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 1,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            segsgn,
    output logic                  ovf
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    bcd_sh;
    logic [BW-1:0]    bcd_adj;
    logic             neg;
    logic             ovf_sticky;
    logic [CW-1:0]    cnt;
    logic             bin_neg;
    logic [WIDTH-1:0] bin_mag;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down so "lead" tracks whether
    // this digit and everything above it is zero.
    function automatic logic [SW-1:0] seg_all(input logic [BW-1:0] b, input logic o);
        logic [SW-1:0] r;
        logic          lead;
        r    = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead && (b[4*i +: 4] == 4'd0);
            if (o)
                r[7*i +: 7] = SEG_DASH;
            else if ((BLANK != 0) && (i > 0) && lead)
                r[7*i +: 7] = SEG_BLANK;
            else
                r[7*i +: 7] = seg_digit(b[4*i +: 4]);
        end
        return r;
    endfunction

    assign bin_neg = (SIGNED != 0) && bin[WIDTH-1];
    assign bin_mag = bin_neg ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;

    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (cnt == CW'(WIDTH)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mag        <= '0;
            neg        <= 1'b0;
            bcd_sh     <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            bcd        <= '0;
            seg        <= seg_all('0, 1'b0);
            segsgn     <= SEG_BLANK;
            ovf        <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag        <= bin_mag;
                        neg        <= bin_neg;
                        bcd_sh     <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                    end
                end
                CONV: begin
                    if (cnt != CW'(WIDTH)) begin
                        mag        <= {mag[WIDTH-2:0], 1'b0};
                        bcd_sh     <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
                        ovf_sticky <= ovf_sticky | bcd_adj[BW-1];
                        cnt        <= cnt + CW'(1);
                    end else begin
                        // A zero magnitude never shows a minus sign.
                        bcd    <= bcd_sh;
                        ovf    <= ovf_sticky;
                        seg    <= seg_all(bcd_sh, ovf_sticky);
                        segsgn <= (neg && ((bcd_sh != '0) || ovf_sticky)) ? SEG_DASH : SEG_BLANK;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bcd_seg_disp_seq.md
Name: bcd_seg_disp_seq

Overview:
- Sequential signed binary-to-BCD converter with an N-digit seven-segment driver. It is the parametrised successor to the fixed two-digit display path.
- Width, digit count, signedness and leading-zero blanking are all parameters. It adds a start/busy/done handshake, sign display and overflow indication.
- It sits between the ALU result/operand muxes and the board's seven-segment displays. One instance is used per displayed value.

Parameters:
- WIDTH, 12, input binary width in bits (>=2).
- DIGITS, 4, number of BCD digits/segment displays (>=1).
- SIGNED, 1, 1 = treat bin as two's complement; 0 = unsigned.
- BLANK, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  WIDTH  binary value to convert
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new results are presented
- bcd  output  4*DIGITS  magnitude in BCD; digit 0 in [3:0]
- seg  output  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 in [6:0]
- segsgn  output  7  sign display: dash 7'b0111111 if negative, blank 7'h7F otherwise
- ovf  output  1  magnitude does not fit in DIGITS decimal digits

Behaviour:
- Reset: one clock and synchronous active-high reset; rst dominates all other inputs in the same cycle.
  - State goes to IDLE; busy=0, done=0, ovf=0, bcd=0, segsgn=7'h7F.
  - seg digit 0 = 7'b1000000 ("0"). Other digits are 7'h7F if BLANK=1, else "0".
- Reset mid-conversion aborts the conversion; there is no done pulse and outputs take their reset values.
- States are IDLE, CONV and DONE.
- IDLE: on start=1, latch bin and go to CONV.
  - Latched magnitude = (SIGNED && bin[WIDTH-1]) ? (~bin+1) : bin, held as WIDTH-bit unsigned. For -2^(WIDTH-1) the magnitude is 2^(WIDTH-1).
  - Latched neg = SIGNED && bin[WIDTH-1].
  - Iteration counter is cleared and the BCD shift register is cleared.
- CONV: runs exactly WIDTH cycles, one double-dabble iteration per cycle.
  - Each iteration first adds 3 to every BCD nibble >=5, then shifts {bcd_shift, magnitude} left by 1.
  - Any 1 shifted out of the top nibble sets the sticky overflow flag.
  - After the WIDTH-th iteration, go to DONE.
- DONE: lasts one cycle, then returns to IDLE.
  - done=1 for that cycle. bcd, seg, segsgn and ovf update on the clock edge entering DONE, so they are valid while done=1.
  - Outputs then hold until the next DONE or reset.
- busy=1 in CONV and DONE, 0 in IDLE.
- Latency: start sampled at edge k; done=1 during the cycle after edge k+WIDTH+1. WIDTH=12 gives 13 cycles from the start edge to the done cycle.
- start while busy is ignored. start asserted in the DONE cycle is also ignored. start held high continuously retriggers from IDLE on every pass.
- bin changes after the start sample have no effect on the conversion in progress.
- Segment decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking (BLANK=1): digit i>0 is blank (7'h7F) if it and all higher digits are 0. Digit 0 is never blanked.
- Overflow (ovf=1):
  - bcd shows the truncated low DIGITS digits.
  - Every seg digit shows dash 7'b0111111.
  - segsgn still reflects the sign.
- Zero result: neg forced 0, so segsgn is blank. Negative zero cannot occur.

Test Plan:
- WIDTH=12, DIGITS=4: rst high 2 cycles -> busy=0, done=0, bcd=0, seg[6:0]=7'b1000000, seg[27:7] all 7'h7F, segsgn=7'h7F.
- start=1 for 1 cycle with bin=1234 (12'h4D2) -> busy high, done pulses exactly 13 cycles after the start edge.
  - bcd=16'h1234, ovf=0, segsgn=7'h7F.
  - seg digits 3..0 = 1111001, 0100100, 0110000, 0011001.
- bin=12'h800 (-2048), SIGNED=1 -> bcd=16'h2048, segsgn=7'b0111111, ovf=0.
- bin=12'hFFF (-1) -> bcd=16'h0001; digits 3..1 blank; segsgn dash.
- DIGITS=3, bin=1234 -> ovf=1, bcd=12'h234, all three seg digits 7'b0111111.
- Control corner cases:
  - Restart during busy: pulse start with bin=5, then pulse start with bin=7 at cycle +4 -> single done, bcd=5.
  - Reset at cycle +6 of a conversion -> no done pulse, outputs at reset values.
  - New start after that reset converts normally.
